// File: rtl/gray_count_sequencer.sv
// Command-driven binary/Gray counter: LOAD or RUN_UP/RUN_DOWN for N steps over valid/ready.
// Steps land one per cycle after accept; cmd_ready is low from accept until the FSM returns to IDLE.
module gray_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_val,
   input  logic             abort,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             c_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] OP_LOAD     = 2'b00;
   localparam logic [1:0] OP_RUN_UP   = 2'b01;
   localparam logic [1:0] OP_RUN_DOWN = 2'b10;
   localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] remaining, remaining_next;
   logic [WIDTH-1:0] bin_next;
   logic             down, down_next;
   logic             c_next;
   logic             accept;

   assign cmd_ready = (state == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign gray      = bin ^ (bin >> 1);
   assign busy      = (state == RUN);
   assign done      = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bin       <= '0;
         remaining <= '0;
         down      <= 1'b0;
         c_out     <= 1'b0;
      end else begin
         state     <= state_next;
         bin       <= bin_next;
         remaining <= remaining_next;
         down      <= down_next;
         c_out     <= c_next;
      end
   end

   always_comb begin
      state_next     = state;
      bin_next       = bin;
      remaining_next = remaining;
      down_next      = down;
      c_next         = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = DONE;
               case (cmd_op)
                  OP_LOAD: bin_next = cmd_val;
                  OP_RUN_UP, OP_RUN_DOWN: begin
                     if (cmd_val != '0) begin
                        remaining_next = cmd_val;
                        down_next      = (cmd_op == OP_RUN_DOWN);
                        state_next     = RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Abort wins over the final step: no bin update on the abort edge.
            if (abort) begin
               remaining_next = '0;
               state_next     = DONE;
            end else begin
               if (down) begin
                  bin_next = bin - ONE;
                  c_next   = (bin == '0);
               end else begin
                  bin_next = bin + ONE;
                  c_next   = (bin == '1);
               end
               remaining_next = remaining - ONE;
               if (remaining == ONE) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Directed-vector bench for gray_count_sequencer; inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_gray_count_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_val;
   logic       abort;
   logic [3:0] bin;
   logic [3:0] gray;
   logic       c_out;
   logic       busy;
   logic       done;

   int vec_cnt = 0;
   int err_cnt = 0;

   gray_count_sequencer #(.WIDTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_val   (cmd_val),
      .abort     (abort),
      .bin       (bin),
      .gray      (gray),
      .c_out     (c_out),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command for one edge; op/val are scrambled afterwards since they are don't-care.
   task automatic issue(input logic [1:0] op, input logic [3:0] val);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_val   = val;
      chk("ready_before_accept", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_val   = 4'($urandom_range(0, 15));
   endtask

   task automatic obs(input string tag, input logic [3:0] eb, input logic [3:0] eg,
                      input logic ec, input logic ebusy, input logic edone);
      chk({tag, ".bin"},   bin,   eb);
      chk({tag, ".gray"},  gray,  eg);
      chk({tag, ".c_out"}, c_out, ec);
      chk({tag, ".busy"},  busy,  ebusy);
      chk({tag, ".done"},  done,  edone);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_val = 4'h0; abort = 1'b0;
      cmd_valid = 1'b1;
      tick(); tick();
      chk("rst.ready", cmd_ready, 0);
      obs("rst", 4'h0, 4'h0, 0, 0, 0);
      cmd_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("idle.ready", cmd_ready, 1);

      // LOAD 1
      issue(2'b00, 4'h1);
      obs("load1", 4'h1, 4'h1, 0, 0, 1);
      chk("load1.ready", cmd_ready, 0);
      tick();
      obs("load1.idle", 4'h1, 4'h1, 0, 0, 0);

      // RUN_UP 3 from 1
      issue(2'b01, 4'd3);
      obs("up3.acc", 4'h1, 4'h1, 0, 1, 0);
      chk("up3.ready", cmd_ready, 0);
      tick(); obs("up3.s1", 4'h2, 4'b0011, 0, 1, 0);
      tick(); obs("up3.s2", 4'h3, 4'b0010, 0, 1, 0);
      tick(); obs("up3.s3", 4'h4, 4'b0110, 0, 0, 1);
      chk("up3.ready_done", cmd_ready, 0);
      tick(); obs("up3.idle", 4'h4, 4'b0110, 0, 0, 0);

      // Wrap up: LOAD F then RUN_UP 1
      issue(2'b00, 4'hF);
      obs("loadF", 4'hF, 4'b1000, 0, 0, 1);
      tick();
      issue(2'b01, 4'd1);
      obs("up1.acc", 4'hF, 4'b1000, 0, 1, 0);
      tick(); obs("up1.wrap", 4'h0, 4'h0, 1, 0, 1);
      tick(); obs("up1.idle", 4'h0, 4'h0, 0, 0, 0);

      // Wrap down: RUN_DOWN 2 from 0
      issue(2'b10, 4'd2);
      obs("dn2.acc", 4'h0, 4'h0, 0, 1, 0);
      tick(); obs("dn2.s1", 4'hF, 4'b1000, 1, 1, 0);
      tick(); obs("dn2.s2", 4'hE, 4'b1001, 0, 0, 1);
      tick(); obs("dn2.idle", 4'hE, 4'b1001, 0, 0, 0);

      // Abort at 3rd edge in RUN of RUN_UP 10 from 0
      issue(2'b00, 4'h0);
      tick();
      issue(2'b01, 4'd10);
      tick(); obs("ab.s1", 4'h1, 4'h1, 0, 1, 0);
      tick(); obs("ab.s2", 4'h2, 4'b0011, 0, 1, 0);
      abort = 1'b1;
      tick(); obs("ab.edge", 4'h2, 4'b0011, 0, 0, 1);
      abort = 1'b0;
      tick(); obs("ab.idle", 4'h2, 4'b0011, 0, 0, 0);
      chk("ab.ready", cmd_ready, 1);
      abort = 1'b1;
      tick(); obs("ab.idle_ignored", 4'h2, 4'b0011, 0, 0, 0);
      chk("ab.idle_ready", cmd_ready, 1);
      abort = 1'b0;

      // Abort coinciding with the final step of RUN_UP 2 from 2
      issue(2'b01, 4'd2);
      tick(); obs("abl.s1", 4'h3, 4'b0010, 0, 1, 0);
      abort = 1'b1;
      tick(); obs("abl.edge", 4'h3, 4'b0010, 0, 0, 1);
      abort = 1'b0;
      tick(); obs("abl.idle", 4'h3, 4'b0010, 0, 0, 0);

      // RUN_UP N=0 and NOP
      issue(2'b01, 4'd0);
      obs("up0", 4'h3, 4'b0010, 0, 0, 1);
      tick(); obs("up0.idle", 4'h3, 4'b0010, 0, 0, 0);
      issue(2'b11, 4'h9);
      obs("nop", 4'h3, 4'b0010, 0, 0, 1);
      tick();

      // Reset mid-RUN after 2 steps of N=5
      issue(2'b01, 4'd5);
      tick(); obs("rr.s1", 4'h4, 4'b0110, 0, 1, 0);
      tick(); obs("rr.s2", 4'h5, 4'b0111, 0, 1, 0);
      reset = 1'b1;
      tick(); obs("rr.reset", 4'h0, 4'h0, 0, 0, 0);
      chk("rr.ready_in_reset", cmd_ready, 0);
      reset = 1'b0;
      #1;
      chk("rr.ready_after", cmd_ready, 1);
      tick(); obs("rr.idle", 4'h0, 4'h0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/gray_count_sequencer.md
# gray_count_sequencer

Command-driven controller for the design's Gray-code counter datapath. It owns the binary count register and accepts LOAD and RUN commands over a valid/ready handshake. It steps the count up or down for a programmed number of cycles and presents the Gray-coded value, a wrap carry, and completion status. It sits between the system control logic and any consumer of the Gray count, such as a cross-domain pointer or a position encoder.

## Interface

- WIDTH, 4, count width in bits; the step count field has the same width.

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 LOAD, 01 RUN_UP, 10 RUN_DOWN, 11 NOP (reserved)
- cmd_val  in  WIDTH  LOAD: binary value to load; RUN_*: number of steps N
- abort  in  1  stops an in-progress RUN; ignored outside RUN
- bin  out  WIDTH  current binary count (registered)
- gray  out  WIDTH  bin ^ (bin >> 1); combinational from the bin register
- c_out  out  1  one-cycle wrap pulse
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse

## Operation

- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: bin=0, gray=0, c_out=0, busy=0, done=0, step counter=0.
- cmd_ready = (state==IDLE) && !reset.
- A command is accepted at a rising edge where cmd_valid && cmd_ready.
- cmd_op and cmd_val are sampled only at acceptance and are don't-care at all other times.
- LOAD: bin <= cmd_val at the accept edge; next state DONE; c_out stays 0.
- RUN_UP / RUN_DOWN with N>0:
  - At the accept edge, remaining <= N, the direction is latched, and the next state is RUN.
  - bin does not change at the accept edge.
- RUN_* with N=0: next state DONE; bin unchanged.
- NOP: next state DONE; no other effect.
- Each edge in RUN with abort=0:
  - bin <= bin ± 1, modulo 2^WIDTH.
  - remaining <= remaining − 1.
  - When remaining==1, the next state is DONE.
- Each edge in RUN with abort=1: no step, remaining is cleared, next state DONE. Abort takes priority over a simultaneous final step.
- DONE lasts exactly one cycle (done=1), then the FSM returns to IDLE.
- Wrap: any step from 2^WIDTH−1 to 0 (up), or from 0 to 2^WIDTH−1 (down), sets c_out=1 for the cycle in which bin holds the wrapped value. Otherwise c_out=0.
- busy = (state==RUN). done = (state==DONE). Both are decoded from the registered state.
- Reset asserted in any state, including mid-RUN, returns the block to reset values at that edge; the run is discarded.
- Outputs hold their values in IDLE indefinitely.

## Timing

- Accept at edge k of RUN with N≥1:
  - busy is high from cycle k+1 through the cycle ending at edge k+N.
  - Steps land at edges k+1 … k+N.
  - done is high in the cycle after edge k+N.
  - cmd_ready returns after edge k+N+1.
  - Command-to-command throughput is N+2 cycles.
- Accept at edge k of LOAD, NOP or N=0: any new bin value is visible after edge k. done is high for one cycle after edge k. IDLE resumes after edge k+1 (2-cycle throughput).
- gray changes in the same cycle as bin; there is no extra latency.
- Exactly one bit of gray changes per step, including on wrap.
- Abort sampled at edge j in RUN: DONE follows after edge j, and bin keeps the value it held before edge j.

## Test plan

- Reset, then LOAD 4'h1 → bin=0001, gray=0001, done for 1 cycle; during reset, cmd_ready=0 and all outputs are 0.
- From bin=1, RUN_UP N=3 → gray sequence 0011, 0010, 0110 on consecutive edges; busy for 3 cycles; done on the 4th cycle after accept; c_out stays 0.
- LOAD 4'hF, then RUN_UP N=1 → bin=0000, gray=0000, c_out=1 for exactly that cycle.
- From bin=0, RUN_DOWN N=2 → bin=1111 (gray 1000) with c_out=1, then bin=1110 (gray 1001) with c_out=0.
- From bin=0, RUN_UP N=10, with abort asserted at the 3rd edge in RUN → final bin=2, done one cycle later, no further steps. Also cover abort at the final-step edge → that step is suppressed.
- RUN_UP N=0 → done in the next cycle, bin unchanged, busy never high. Reset asserted mid-RUN (after 2 steps of N=5) → bin=0 and the FSM is IDLE at the next edge; no done pulse.
